data_bus_ctrl: RTL

- Parametrised, sequential successor of the core data bus: accepts one load/store per request handshake, decodes the address into DATA RAM, IO or CSR regions, and returns sized, extended read data with a fixed-latency response.
- Adds byte-granular writes, access-size/alignment checking, an exception cause code and a real memory-mapped LED register.
- Sits between the core load/store unit and the on-chip memories.

---
 rtl/data_bus_pkg.sv | 80 ++++++++
 rtl/data_bus_ctrl_bus_ram.sv | 49 ++++
 rtl/data_bus_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_pkg
// Shared definitions for the data bus controller:
//   - access size encoding (SZ_B/SZ_H/SZ_W/SZ_D)
//   - exception cause codes (EXC_NONE/EXC_MISALIGN/EXC_UNMAPPED/EXC_RO)
//   - controller FSM state type and read-data source select type
//   - CSR_ID, the constant returned by the read-only CSR at offset 0
//   - helpers: byte strobe generation, alignment mask, load extension
// The helpers work on a 64-bit dword with 8 byte lanes.
// -----------------------------------------------------------------------------
package data_bus_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] EXC_NONE     = 2'd0;
   localparam logic [1:0] EXC_MISALIGN = 2'd1;
   localparam logic [1:0] EXC_UNMAPPED = 2'd2;
   localparam logic [1:0] EXC_RO       = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   // Where the response data of a read comes from.
   typedef enum logic [1:0] {
      SRC_DATA,
      SRC_CSR,
      SRC_IMM
   } rd_src_t;

   localparam logic [63:0] CSR_ID = 64'h0000_0000_DB5C_0001;

   // Byte strobe: (2^size) ones, moved to the addressed lane.
   function automatic logic [7:0] gen_strobe(input logic [1:0] size, input logic [2:0] lo);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << lo;
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_mask(input logic [1:0] size);
      logic [2:0] m;
      case (size)
         SZ_B:    m = 3'b000;
         SZ_H:    m = 3'b001;
         SZ_W:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return m;
   endfunction

   // Shift the addressed bytes down to bit 0, keep 2^size bytes, then
   // sign- or zero-extend to 64 bits.
   function automatic logic [63:0] load_extend(input logic [63:0] dword,
                                               input logic [1:0]  size,
                                               input logic [2:0]  lo,
                                               input logic        zext);
      logic [63:0] sh;
      logic [63:0] res;
      sh = dword >> {lo, 3'b000};
      case (size)
         SZ_B:    res = zext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         SZ_H:    res = zext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         SZ_W:    res = zext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/data_bus_ctrl_bus_ram.sv
// -----------------------------------------------------------------------------
// bus_ram
// Byte-enable synchronous RAM, one dword per word, registered read.
// Each byte lane is its own array so block RAM inference sees a plain
// single-writer memory per lane.
// Ports:
//   clk    in  clock, rising edge
//   en     in  access enable (read and/or write this cycle)
//   we     in  write enable (qualified by en)
//   be     in  DW/8 byte enables
//   addr   in  word address (byte address bits [AW-1:3])
//   wdata  in  lane-aligned write data
//   rdata  out registered read data (read-before-write)
// -----------------------------------------------------------------------------
module bus_ram #(
   parameter int AW = 12,
   parameter int DW = 64
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [DW/8-1:0]   be,
   input  logic [AW-4:0]     addr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata
);

   localparam int DEPTH = 1 << (AW - 3);

   genvar gi;
   generate
      for (gi = 0; gi < DW / 8; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] q_reg;

         always_ff @(posedge clk) begin
            if (en) begin
               if (we && be[gi]) begin
                  lane_mem[addr] <= wdata[gi*8 +: 8];
               end
               q_reg <= lane_mem[addr];
            end
         end

         assign rdata[gi*8 +: 8] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl
// Load/store controller between the core LSU and on-chip memories.
// One request per handshake; IDLE -> ACCESS -> RESP, so a response strobe
// appears two cycles after the accept cycle and requests complete every
// three cycles. Decodes DATA RAM, CSR RAM and the IO LED register, checks
// alignment / mapping / read-only, performs byte-strobed writes and returns
// sized, sign- or zero-extended load data.
// Ports:
//   clk, rst_n       clock (rising) / asynchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_rw           1 = store, 0 = load
//   req_len          [1:0] size, [2] zero-extend loads
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   rsp_valid        one-cycle response strobe
//   rsp_rdata        extended load data, 0 for stores and faults
//   rsp_exc          fault flag, valid with rsp_valid
//   rsp_cause        fault cause, valid with rsp_valid
//   led              memory-mapped LED register
// -----------------------------------------------------------------------------
module data_bus_ctrl
   import data_bus_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int RAM_AW       = 12,
   parameter int CSR_AW       = 6,
   parameter int REGION_SHIFT = 16,
   parameter int CSR_TAG      = 0,
   parameter int DATA_TAG     = 1,
   parameter int IO_TAG       = 2,
   parameter int LED_OFF      = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_rw,
   input  logic [2:0]      req_len,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_exc,
   output logic [1:0]      rsp_cause,
   output logic [7:0]      led
);

   localparam int TAG_W = XLEN - REGION_SHIFT;

   state_t            state_reg, state_next;
   logic              rw_reg;
   logic [2:0]        len_reg;
   logic [XLEN-1:0]   addr_reg;
   logic [XLEN-1:0]   wdata_reg;
   logic [7:0]        led_reg;
   logic [1:0]        cause_reg;
   rd_src_t           src_reg;
   logic [XLEN-1:0]   imm_reg;

   // ---------------- decode of the latched request ----------------
   logic [TAG_W-1:0]        tag;
   logic [REGION_SHIFT-1:0] off;
   logic [1:0]              size;
   logic [2:0]              lo;
   logic                    hit_data, hit_csr, hit_led, csr_id_hit, misaligned;
   logic [1:0]              cause_now;
   logic                    access_ok;
   rd_src_t                 src_sel;

   assign tag  = addr_reg[XLEN-1:REGION_SHIFT];
   assign off  = addr_reg[REGION_SHIFT-1:0];
   assign size = len_reg[1:0];
   assign lo   = addr_reg[2:0];

   always_comb begin
      hit_data   = (tag == TAG_W'(DATA_TAG)) && ((off >> RAM_AW) == '0);
      hit_csr    = (tag == TAG_W'(CSR_TAG))  && ((off >> CSR_AW) == '0);
      hit_led    = (tag == TAG_W'(IO_TAG))   && (off == REGION_SHIFT'(LED_OFF));
      csr_id_hit = hit_csr && (off == '0);
      misaligned = |(lo & align_mask(size));

      // Alignment outranks mapping; read-only only matters once mapped.
      if (misaligned) begin
         cause_now = EXC_MISALIGN;
      end else if (!(hit_data || hit_csr || hit_led)) begin
         cause_now = EXC_UNMAPPED;
      end else if (csr_id_hit && rw_reg) begin
         cause_now = EXC_RO;
      end else begin
         cause_now = EXC_NONE;
      end
      access_ok = (cause_now == EXC_NONE);

      if (hit_data) begin
         src_sel = SRC_DATA;
      end else if (hit_csr && !csr_id_hit) begin
         src_sel = SRC_CSR;
      end else begin
         src_sel = SRC_IMM;
      end
   end

   // ---------------- memories ----------------
   logic            data_en, csr_en;
   logic [7:0]      strobe;
   logic [XLEN-1:0] wdata_lane;
   logic [XLEN-1:0] data_q, csr_q;

   assign data_en    = (state_reg == ACCESS) && hit_data && access_ok;
   assign csr_en     = (state_reg == ACCESS) && hit_csr && !csr_id_hit && access_ok;
   assign strobe     = gen_strobe(size, lo);
   assign wdata_lane = wdata_reg << {lo, 3'b000};

   bus_ram #(.AW(RAM_AW), .DW(XLEN)) u_data_ram (
      .clk   (clk),
      .en    (data_en),
      .we    (rw_reg),
      .be    (strobe),
      .addr  (addr_reg[RAM_AW-1:3]),
      .wdata (wdata_lane),
      .rdata (data_q)
   );

   bus_ram #(.AW(CSR_AW), .DW(XLEN)) u_csr_ram (
      .clk   (clk),
      .en    (csr_en),
      .we    (rw_reg),
      .be    (strobe),
      .addr  (addr_reg[CSR_AW-1:3]),
      .wdata (wdata_lane),
      .rdata (csr_q)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            state_next = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- request latch, result capture, LED ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_reg    <= 1'b0;
         len_reg   <= 3'd0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         led_reg   <= 8'd0;
         cause_reg <= EXC_NONE;
         src_reg   <= SRC_DATA;
         imm_reg   <= '0;
      end else begin
         if ((state_reg == IDLE) && req_valid) begin
            rw_reg    <= req_rw;
            len_reg   <= req_len;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
         end
         if (state_reg == ACCESS) begin
            cause_reg <= cause_now;
            src_reg   <= src_sel;
            // Non-RAM read sources are captured on the same edge the RAMs
            // register their read data, so all sources line up in RESP.
            imm_reg   <= csr_id_hit ? XLEN'(CSR_ID) : XLEN'(led_reg);
            if (hit_led && rw_reg && access_ok) begin
               led_reg <= wdata_reg[7:0];
            end
         end
      end
   end

   // ---------------- response ----------------
   logic [XLEN-1:0] rd_dword;

   always_comb begin
      case (src_reg)
         SRC_DATA: rd_dword = data_q;
         SRC_CSR:  rd_dword = csr_q;
         default:  rd_dword = imm_reg;
      endcase

      rsp_exc   = rsp_valid && (cause_reg != EXC_NONE);
      rsp_cause = rsp_valid ? cause_reg : EXC_NONE;
      rsp_rdata = '0;
      if (rsp_valid && !rw_reg && (cause_reg == EXC_NONE)) begin
         rsp_rdata = load_extend(rd_dword, size, lo, len_reg[2]);
      end
   end

   assign led = led_reg;

endmodule
